// File: rtl/uart_pkg.sv
// Shared UART definitions: interrupt identifiers, register-file write record
// and the RX FIFO trigger-level decode.
package uart_pkg;

    localparam logic [2:0] ISR_ID_LS   = 3'b011;
    localparam logic [2:0] ISR_ID_RDA  = 3'b010;
    localparam logic [2:0] ISR_ID_TO   = 3'b110;
    localparam logic [2:0] ISR_ID_THRE = 3'b001;
    localparam logic [2:0] ISR_ID_MS   = 3'b000;

    typedef struct packed {
        logic [7:0] isr;
        logic       isr_valid;
    } intrpt_reg_write_t;

    function automatic logic [4:0] rx_trigger_level(input logic [1:0] code);
        logic [4:0] lvl;
        case (code)
            2'b00:   lvl = 5'd1;
            2'b01:   lvl = 5'd4;
            2'b10:   lvl = 5'd8;
            default: lvl = 5'd14;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// RX character timeout: counts bit times of RX idle while data sits in the
// FIFO and raises a sticky pending flag after TimeoutChars frames.
module uart_rx_timeout #(
    parameter int TimeoutChars = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] lcr_i,
    input  logic       fifo_en_i,
    input  logic [4:0] rx_fifo_level_i,
    input  logic       rx_char_done_i,
    input  logic       obi_read_rhr_i,
    input  logic       bit_tick_i,
    output logic       to_pend_o
);

    localparam int CntW = $clog2(TimeoutChars * 12 + 1);

    logic [3:0]      frame_bits;
    logic [CntW-1:0] limit;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_next;
    logic            clear;

    // start + data (5..8) + parity + stop (1 or 2)
    always_comb begin
        frame_bits = 4'd6 + {2'b00, lcr_i[1:0]} + {3'b000, lcr_i[3]}
                   + (lcr_i[2] ? 4'd2 : 4'd1);
        limit      = CntW'(TimeoutChars * int'(frame_bits));
        clear      = rx_char_done_i | obi_read_rhr_i
                   | (rx_fifo_level_i == 5'd0) | ~fifo_en_i;
        cnt_next   = cnt;
        if (bit_tick_i && (cnt < limit)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Limit is re-evaluated every cycle so an LCR change takes effect at once.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            cnt       <= '0;
            to_pend_o <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (cnt_next >= limit) begin
                to_pend_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_interrupt_ctrl.sv
// 16550A interrupt scheduler: IER gating, fixed-priority arbitration and the
// registered ISR with its change strobe towards the register file.
module uart_interrupt_ctrl
    import uart_pkg::*;
#(
    parameter int TimeoutChars = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ier_i,
    input  logic [7:0] lcr_i,
    input  logic       fcr_fifo_en_i,
    input  logic [1:0] rx_fifo_tl_i,
    input  logic [7:0] lsr_i,
    input  logic [7:0] msr_i,
    input  logic [4:0] rx_fifo_level_i,
    input  logic       rx_char_done_i,
    input  logic       bit_tick_i,
    input  logic       obi_read_rhr_i,
    input  logic       obi_read_isr_i,
    input  logic       obi_write_thr_i,
    output logic [7:0] isr_o,
    output logic       isr_valid_o,
    output logic       irq_o
);

    logic              to_pend;
    logic              thre_pend;
    logic              lsr5_q;
    logic              ier1_q;
    logic              thre_set;
    logic              thre_clr;
    logic              ls_src, rda_src, to_src, thre_src, ms_src;
    logic              any_pend;
    logic [2:0]        isr_id;
    logic [7:0]        isr_next;
    intrpt_reg_write_t isr_reg;
    logic              unused_bits;

    assign unused_bits = ^{lcr_i[7:4], lsr_i[7:6], msr_i[7:4], ier_i[7:4]};

    uart_rx_timeout #(
        .TimeoutChars(TimeoutChars)
    ) u_rx_timeout (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lcr_i          (lcr_i[3:0]),
        .fifo_en_i      (fcr_fifo_en_i),
        .rx_fifo_level_i(rx_fifo_level_i),
        .rx_char_done_i (rx_char_done_i),
        .obi_read_rhr_i (obi_read_rhr_i),
        .bit_tick_i     (bit_tick_i),
        .to_pend_o      (to_pend)
    );

    always_comb begin
        ls_src   = ier_i[2] & (|lsr_i[4:1]);
        rda_src  = ier_i[0] & (fcr_fifo_en_i ? (rx_fifo_level_i >= rx_trigger_level(rx_fifo_tl_i))
                                             : lsr_i[0]);
        to_src   = ier_i[0] & fcr_fifo_en_i & to_pend;
        thre_src = ier_i[1] & thre_pend;
        ms_src   = ier_i[3] & (|msr_i[3:0]);

        any_pend = 1'b1;
        isr_id   = 3'b000;
        if (ls_src) begin
            isr_id = ISR_ID_LS;
        end else if (rda_src) begin
            isr_id = ISR_ID_RDA;
        end else if (to_src) begin
            isr_id = ISR_ID_TO;
        end else if (thre_src) begin
            isr_id = ISR_ID_THRE;
        end else if (ms_src) begin
            isr_id = ISR_ID_MS;
        end else begin
            any_pend = 1'b0;
        end
        isr_next = {(fcr_fifo_en_i ? 2'b11 : 2'b00), 2'b00, isr_id, ~any_pend};
    end

    // THRE is edge-triggered: a new empty condition, or enabling it while empty.
    always_comb begin
        thre_set = (lsr_i[5] & ~lsr5_q) | (ier_i[1] & ~ier1_q & lsr_i[5]);
        thre_clr = obi_write_thr_i | (obi_read_isr_i & (isr_reg.isr[3:1] == ISR_ID_THRE));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lsr5_q    <= 1'b1;
            ier1_q    <= 1'b1;
            thre_pend <= 1'b0;
            isr_reg   <= '{isr: 8'h01, isr_valid: 1'b0};
        end else begin
            lsr5_q <= lsr_i[5];
            ier1_q <= ier_i[1];
            if (thre_set) begin
                thre_pend <= 1'b1;
            end else if (thre_clr) begin
                thre_pend <= 1'b0;
            end
            isr_reg.isr       <= isr_next;
            isr_reg.isr_valid <= (isr_next != isr_reg.isr);
        end
    end

    assign isr_o       = isr_reg.isr;
    assign isr_valid_o = isr_reg.isr_valid;
    assign irq_o       = ~isr_reg.isr[0];

endmodule

// File: tb/tb_uart_interrupt_ctrl.sv
// Scoreboard bench for uart_interrupt_ctrl: a behavioural model predicts the
// sequence of ISR values; a monitor checks each isr_valid_o strobe against it.
module tb_uart_interrupt_ctrl;

    localparam int TO_CHARS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ier, lcr, lsr, msr;
    logic       fifo_en;
    logic [1:0] tl;
    logic [4:0] level;
    logic       rx_done, tick, rd_rhr, rd_isr, wr_thr;
    logic [7:0] isr;
    logic       isr_valid, irq;

    uart_interrupt_ctrl #(.TimeoutChars(TO_CHARS)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ier_i          (ier),
        .lcr_i          (lcr),
        .fcr_fifo_en_i  (fifo_en),
        .rx_fifo_tl_i   (tl),
        .lsr_i          (lsr),
        .msr_i          (msr),
        .rx_fifo_level_i(level),
        .rx_char_done_i (rx_done),
        .bit_tick_i     (tick),
        .obi_read_rhr_i (rd_rhr),
        .obi_read_isr_i (rd_isr),
        .obi_write_thr_i(wr_thr),
        .isr_o          (isr),
        .isr_valid_o    (isr_valid),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    // Reference model state
    logic [7:0] m_ier = 8'h00, m_lcr = 8'h03, m_lsr = 8'h60, m_msr = 8'h00;
    logic       m_fifo = 1'b0;
    logic [1:0] m_tl = 2'b00;
    logic [4:0] m_level = 5'd0;
    logic       m_thre = 1'b0, m_to = 1'b0;
    int         m_ticks = 0;
    logic [7:0] m_last = 8'h01;
    logic       p_lsr5 = 1'b1, p_ier1 = 1'b1;
    int         trig[4] = '{1, 4, 8, 14};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int frame_len();
        return 6 + int'(m_lcr[1:0]) + int'(m_lcr[3]) + (m_lcr[2] ? 2 : 1);
    endfunction

    function automatic logic [7:0] model_isr(input logic thre_f, input logic to_f);
        logic [2:0] id;
        logic       pend;
        pend = 1'b1;
        if (m_ier[2] && (m_lsr[4:1] != 4'b0))                               id = 3'b011;
        else if (m_ier[0] && (m_fifo ? (int'(m_level) >= trig[m_tl]) : m_lsr[0])) id = 3'b010;
        else if (m_ier[0] && m_fifo && to_f)                                id = 3'b110;
        else if (m_ier[1] && thre_f)                                        id = 3'b001;
        else if (m_ier[3] && (m_msr[3:0] != 4'b0))                          id = 3'b000;
        else begin
            id   = 3'b000;
            pend = 1'b0;
        end
        return {(m_fifo ? 2'b11 : 2'b00), 2'b00, id, !pend};
    endfunction

    // Apply the model inputs plus one cycle of pulses; predict and then wait.
    task automatic apply(input bit rxd, input bit rrhr, input bit risr, input bit wthr,
                         input bit tk, input int settle);
        logic       o_thre, o_to, set, clr;
        logic [7:0] inter, fin;
        o_thre = m_thre;
        o_to   = m_to;
        set = (m_lsr[5] && !p_lsr5) || (m_ier[1] && !p_ier1 && m_lsr[5]);
        clr = wthr || (risr && (m_last[3:1] == 3'b001));
        if (set)      m_thre = 1'b1;
        else if (clr) m_thre = 1'b0;
        if (rxd || rrhr || (m_level == 5'd0) || !m_fifo) begin
            m_ticks = 0;
            m_to    = 1'b0;
        end else begin
            if (tk) m_ticks++;
            if (m_ticks >= TO_CHARS * frame_len()) m_to = 1'b1;
        end
        p_lsr5 = m_lsr[5];
        p_ier1 = m_ier[1];
        inter = model_isr(o_thre, o_to);
        fin   = model_isr(m_thre, m_to);
        if (inter != m_last) exp_q.push_back(inter);
        if (fin != inter)    exp_q.push_back(fin);
        m_last = fin;

        ier = m_ier; lcr = m_lcr; lsr = m_lsr; msr = m_msr;
        fifo_en = m_fifo; tl = m_tl; level = m_level;
        rx_done = rxd; rd_rhr = rrhr; rd_isr = risr; wr_thr = wthr; tick = tk;
        @(posedge clk); #1;
        rx_done = 0; rd_rhr = 0; rd_isr = 0; wr_thr = 0; tick = 0;
        if (settle > 0) begin
            repeat (settle) @(posedge clk);
            #1;
            chk("isr_settled", isr, m_last);
            chk("irq_settled", irq, !m_last[0]);
            chk("strobes_consumed", exp_q.size(), 0);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) apply(0, 0, 0, 0, 1, 2);
    endtask

    // Monitor: every ISR strobe must match the next predicted value.
    always @(negedge clk) begin
        if (!rst && isr_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL isr_valid_unexpected: strobe with isr=%0h, none expected (t=%0t)", isr, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("isr_strobe_value", isr, e);
                chk("irq_strobe_value", irq, !e[0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ier = 8'h00; lcr = 8'h03; lsr = 8'h60; msr = 8'h00; fifo_en = 0; tl = 0; level = 0;
        rx_done = 0; tick = 0; rd_rhr = 0; rd_isr = 0; wr_thr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_isr", isr, 8'h01);
        chk("reset_irq", irq, 1'b0);
        chk("reset_valid", isr_valid, 1'b0);
        rst = 0;
        apply(0, 0, 0, 0, 0, 3);
        chk("idle_isr", isr, 8'h01);

        // Priority: LS over RDA, then RDA after LS clears
        m_fifo = 1; apply(0, 0, 0, 0, 0, 3);
        chk("fifo_idle", isr, 8'hC1);
        m_tl = 2'b01; m_level = 5'd4; m_lsr = 8'h62; m_ier = 8'h0F;
        apply(0, 0, 0, 0, 0, 3);
        chk("prio_ls", isr, 8'hC6);
        m_lsr = 8'h60; apply(0, 0, 0, 0, 0, 3);
        chk("prio_rda", isr, 8'hC4);
        m_level = 5'd0; apply(0, 0, 0, 0, 0, 3);
        chk("prio_thre", isr, 8'hC2);
        apply(0, 0, 1, 0, 0, 3);
        chk("thre_read_clear", isr, 8'hC1);

        // Timeout: 8N1, level below trigger
        m_ier = 8'h01; m_lcr = 8'h03; m_level = 5'd1; apply(0, 0, 0, 0, 0, 3);
        ticks(39);
        chk("to_before_limit", isr, 8'hC1);
        apply(0, 0, 0, 0, 1, 0);
        @(negedge clk); chk("to_latency_early", isr, 8'hC1);
        @(negedge clk); chk("to_latency", isr, 8'hCC);
        chk("to_irq", irq, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        m_level = 5'd0; apply(0, 1, 0, 0, 0, 3);
        chk("to_cleared", isr, 8'hC1);

        // Timeout restart by a new character on tick 39
        m_level = 5'd1; apply(0, 0, 0, 0, 0, 3);
        ticks(38);
        apply(1, 0, 0, 0, 1, 3);
        ticks(39);
        chk("restart_no_to", isr, 8'hC1);
        ticks(1);
        chk("restart_to", isr, 8'hCC);
        m_level = 5'd0; apply(0, 0, 0, 0, 0, 3);

        // THRE set/clear behaviour
        m_lsr = 8'h40; apply(0, 0, 0, 0, 0, 3);
        m_ier = 8'h02; apply(0, 0, 0, 0, 0, 3);
        chk("thre_idle", isr, 8'hC1);
        m_lsr = 8'h60; apply(0, 0, 0, 0, 0, 3);
        chk("thre_rise", isr, 8'hC2);
        apply(0, 0, 1, 0, 0, 3);
        chk("thre_isr_read", isr, 8'hC1);
        m_ier = 8'h00; apply(0, 0, 0, 0, 0, 3);
        m_ier = 8'h02; apply(0, 0, 0, 0, 0, 3);
        chk("thre_ier_rise", isr, 8'hC2);
        apply(0, 0, 0, 1, 0, 3);
        chk("thre_write", isr, 8'hC1);
        m_lsr = 8'h40; apply(0, 0, 0, 0, 0, 3);
        m_lsr = 8'h60; apply(0, 0, 0, 1, 0, 3);
        chk("thre_set_wins", isr, 8'hC2);
        apply(0, 0, 0, 1, 0, 3);

        // Modem status in non-FIFO mode
        m_fifo = 0; m_ier = 8'h08; m_msr = 8'h01; apply(0, 0, 0, 0, 0, 3);
        chk("ms_isr", isr, 8'h00);
        chk("ms_irq", irq, 1'b1);
        m_msr = 8'h00; apply(0, 0, 0, 0, 0, 3);
        chk("ms_clear", isr, 8'h01);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                0: m_ier = 8'($urandom);
                1: m_lsr = 8'($urandom);
                2: m_msr = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
                3: m_level = 5'($urandom_range(0, 16));
                4: begin
                    m_tl   = 2'($urandom);
                    m_fifo = ($urandom_range(0, 3) != 0);
                end
                5: m_lcr = 8'($urandom);
                6: ticks($urandom_range(1, 25));
                default: ;
            endcase
            case ($urandom_range(0, 5))
                0: apply(1, 0, 0, 0, 0, 3);
                1: apply(0, 1, 0, 0, 0, 3);
                2: apply(0, 0, 1, 0, 0, 3);
                3: apply(0, 0, 0, 1, 0, 3);
                default: apply(0, 0, 0, 0, 0, 3);
            endcase
        end

        // Reset in the middle of activity
        m_fifo = 1; m_ier = 8'h0F; m_lsr = 8'h62; apply(0, 0, 0, 0, 0, 3);
        rst = 1;
        @(posedge clk); #1;
        chk("midreset_isr", isr, 8'h01);
        chk("midreset_irq", irq, 1'b0);
        chk("midreset_valid", isr_valid, 1'b0);
        m_ier = 8'h00; m_lsr = 8'h60; m_msr = 8'h00; m_level = 5'd0;
        m_thre = 0; m_to = 0; m_ticks = 0; m_last = 8'h01; p_lsr5 = 1; p_ier1 = 1;
        ier = m_ier; lsr = m_lsr; msr = m_msr; level = m_level;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        apply(0, 0, 0, 0, 0, 3);
        chk("post_reset_isr", isr, 8'hC1);

        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
